// File: rtl/route_seq_ctrl.sv
// Sequencer for the route stage between the M1 matrix unit and the M2 sigmoid LUT.
// Runs M1 capture/LUT/writeback passes or GSRAM bypass passes; every output is registered.
module route_seq_ctrl #(
  parameter int NUM_WORDS = 10,
  parameter int LUT_LAT   = 2,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              Gate,
  output logic              RegLoadEn,
  output logic              RegLoadSel,
  output logic [ADDR_W-1:0] Addr,
  output logic              DataOutSel,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              lut_start,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W    = $clog2(LUT_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(LUT_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WAIT,
    S_WB,
    S_SRAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gate_q, gate_d;
  logic              reg_load_en_q, reg_load_en_d;
  logic              reg_load_sel_q, reg_load_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              data_out_sel_q, data_out_sel_d;
  logic              sram_rd_en_q, sram_rd_en_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              lut_start_q, lut_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state logic; abort overrides every transition, including start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (start) state_d = mode ? S_SRAM : S_LOAD;
      end
      S_LOAD:  state_d = S_READ;
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = LAT_CNT;
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_SRAM: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FLUSH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    gate_d         = (state_d == S_LOAD) || (state_d == S_READ) || (state_d == S_WB);
    reg_load_en_d  = (state_d == S_LOAD) || (state_d == S_WB);
    reg_load_sel_d = (state_d == S_WB);
    addr_d         = '0;
    if ((state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_WB)) addr_d = idx_d;
    data_out_sel_d = (state_d == S_SRAM) || (state_d == S_FLUSH);
    sram_rd_en_d   = (state_d == S_SRAM);
    sram_addr_d    = (state_d == S_SRAM) ? idx_d : '0;
    // GSRAM data arrives one cycle after the read strobe, so bypass lut_start trails it.
    lut_start_d    = !abort && (((state_q == S_READ) && (state_d == S_WAIT)) || sram_rd_en_q);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      gate_q         <= 1'b0;
      reg_load_en_q  <= 1'b0;
      reg_load_sel_q <= 1'b0;
      addr_q         <= '0;
      data_out_sel_q <= 1'b0;
      sram_rd_en_q   <= 1'b0;
      sram_addr_q    <= '0;
      lut_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      gate_q         <= gate_d;
      reg_load_en_q  <= reg_load_en_d;
      reg_load_sel_q <= reg_load_sel_d;
      addr_q         <= addr_d;
      data_out_sel_q <= data_out_sel_d;
      sram_rd_en_q   <= sram_rd_en_d;
      sram_addr_q    <= sram_addr_d;
      lut_start_q    <= lut_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign Gate       = gate_q;
  assign RegLoadEn  = reg_load_en_q;
  assign RegLoadSel = reg_load_sel_q;
  assign Addr       = addr_q;
  assign DataOutSel = data_out_sel_q;
  assign sram_rd_en = sram_rd_en_q;
  assign sram_addr  = sram_addr_q;
  assign lut_start  = lut_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
